// File: rtl/fft_seq_if.sv
// Butterfly handshake bundle between the FFT sequencer and the datapath.
// Carries the register pair, twiddle index and current stage.
interface fft_seq_if #(
  parameter int LOG2_N = 6
);
  localparam int SW = $clog2(LOG2_N);

  logic              bf_valid;
  logic              bf_ready;
  logic [LOG2_N-1:0] idx_a;
  logic [LOG2_N-1:0] idx_b;
  logic [LOG2_N-2:0] tw_idx;
  logic [SW-1:0]     stage;

  modport master (
    output bf_valid, idx_a, idx_b, tw_idx, stage,
    input  bf_ready
  );

  modport slave (
    input  bf_valid, idx_a, idx_b, tw_idx, stage,
    output bf_ready
  );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Radix-2 DIT butterfly sequencer: load, per-stage butterflies, flush, done.
// Optional FFT_SEQ_STALL_CNT_EN adds a saturating stall cycle counter.
module fft_stage_sequencer #(
  parameter int N_POINTS   = 64,
  parameter int LOG2_N     = 6,
  parameter int PIPE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        load_en,
  output logic        busy,
  output logic        done,
`ifdef FFT_SEQ_STALL_CNT_EN
  output logic [15:0] stall_cnt,
`endif
  fft_seq_if.master   bf
);
  localparam int KW   = LOG2_N - 1;
  localparam int SW   = $clog2(LOG2_N);
  localparam int HALF = N_POINTS / 2;

  localparam logic [KW-1:0] K_LAST = KW'(HALF - 1);
  localparam logic [SW-1:0] S_LAST = SW'(LOG2_N - 1);
  localparam logic [2:0]    F_LAST =
    3'((PIPE_DEPTH > 0) ? PIPE_DEPTH - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_FLUSH, S_DONE
  } state_t;

  state_t        st;
  logic [KW-1:0] k;
  logic [2:0]    fcnt;
  logic [KW-1:0] k_nx;
  logic [SW-1:0] s_nx;
  logic          last_s;

  assign k_nx   = k + KW'(1);
  assign s_nx   = bf.stage + SW'(1);
  assign last_s = (bf.stage == S_LAST);

  // Upper leg: group base (grp * 2 * span) plus position within span.
  function automatic logic [LOG2_N-1:0] calc_a(
    input logic [KW-1:0] kk,
    input logic [SW-1:0] s
  );
    logic [LOG2_N-1:0] kx;
    logic [LOG2_N-1:0] msk;
    kx  = {1'b0, kk};
    msk = (LOG2_N'(1) << s) - LOG2_N'(1);
    return (((kx >> s) << 1) << s) | (kx & msk);
  endfunction

  function automatic logic [LOG2_N-1:0] calc_b(
    input logic [KW-1:0] kk,
    input logic [SW-1:0] s
  );
    return calc_a(kk, s) + (LOG2_N'(1) << s);
  endfunction

  function automatic logic [KW-1:0] calc_tw(
    input logic [KW-1:0] kk,
    input logic [SW-1:0] s
  );
    logic [KW-1:0] msk;
    msk = (KW'(1) << s) - KW'(1);
    return (kk & msk) << (SW'(KW) - s);
  endfunction

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      st          <= S_IDLE;
      k           <= '0;
      fcnt        <= '0;
      load_en     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bf.bf_valid <= 1'b0;
      bf.idx_a    <= '0;
      bf.idx_b    <= '0;
      bf.tw_idx   <= '0;
      bf.stage    <= '0;
    end else if (abort) begin
      // Indices keep their last values; only control state clears.
      st          <= S_IDLE;
      k           <= '0;
      fcnt        <= '0;
      load_en     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bf.bf_valid <= 1'b0;
      bf.stage    <= '0;
    end else begin
      unique case (st)
        S_IDLE: begin
          if (start) begin
            st      <= S_LOAD;
            load_en <= 1'b1;
            busy    <= 1'b1;
          end
        end
        S_LOAD: begin
          st          <= S_RUN;
          load_en     <= 1'b0;
          k           <= '0;
          bf.stage    <= '0;
          bf.bf_valid <= 1'b1;
          bf.idx_a    <= calc_a('0, '0);
          bf.idx_b    <= calc_b('0, '0);
          bf.tw_idx   <= calc_tw('0, '0);
        end
        S_RUN: begin
          if (bf.bf_ready) begin
            if (k != K_LAST) begin
              k         <= k_nx;
              bf.idx_a  <= calc_a(k_nx, bf.stage);
              bf.idx_b  <= calc_b(k_nx, bf.stage);
              bf.tw_idx <= calc_tw(k_nx, bf.stage);
            end else if (PIPE_DEPTH != 0) begin
              st          <= S_FLUSH;
              fcnt        <= '0;
              bf.bf_valid <= 1'b0;
            end else if (!last_s) begin
              k         <= '0;
              bf.stage  <= s_nx;
              bf.idx_a  <= calc_a('0, s_nx);
              bf.idx_b  <= calc_b('0, s_nx);
              bf.tw_idx <= calc_tw('0, s_nx);
            end else begin
              st          <= S_DONE;
              bf.bf_valid <= 1'b0;
              done        <= 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (fcnt != F_LAST) begin
            fcnt <= fcnt + 3'd1;
          end else if (!last_s) begin
            st          <= S_RUN;
            k           <= '0;
            bf.stage    <= s_nx;
            bf.bf_valid <= 1'b1;
            bf.idx_a    <= calc_a('0, s_nx);
            bf.idx_b    <= calc_b('0, s_nx);
            bf.tw_idx   <= calc_tw('0, s_nx);
          end else begin
            st   <= S_DONE;
            done <= 1'b1;
          end
        end
        S_DONE: begin
          st   <= S_IDLE;
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

`ifdef FFT_SEQ_STALL_CNT_EN
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (st == S_IDLE && start && !abort) begin
      stall_cnt <= '0;
    end else if (st == S_RUN && bf.bf_valid && !bf.bf_ready
                 && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Randomised self-checking bench for fft_stage_sequencer.
// Two instances: N=8/PIPE=2 and N=64/PIPE=0, observed through a mux.
module tb_fft_stage_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic rdy = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit sel = 1'b0;
  int N = 8, L = 3, P = 2;

  fft_seq_if #(.LOG2_N(3)) ifa ();
  fft_seq_if #(.LOG2_N(6)) ifb ();
  assign ifa.bf_ready = rdy;
  assign ifb.bf_ready = rdy;

  logic la, ba, da, lb, bb, db;
`ifdef FFT_SEQ_STALL_CNT_EN
  logic [15:0] sa, sb, o_stall;
`endif

  fft_stage_sequencer #(.N_POINTS(8), .LOG2_N(3), .PIPE_DEPTH(2)) u_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .load_en(la), .busy(ba), .done(da),
`ifdef FFT_SEQ_STALL_CNT_EN
    .stall_cnt(sa),
`endif
    .bf(ifa)
  );

  fft_stage_sequencer #(.N_POINTS(64), .LOG2_N(6), .PIPE_DEPTH(0)) u_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .load_en(lb), .busy(bb), .done(db),
`ifdef FFT_SEQ_STALL_CNT_EN
    .stall_cnt(sb),
`endif
    .bf(ifb)
  );

  logic [5:0] o_a, o_b, o_tw;
  logic [2:0] o_st;
  logic o_valid, o_load, o_busy, o_done;
  assign o_a     = sel ? ifb.idx_a : {3'b0, ifa.idx_a};
  assign o_b     = sel ? ifb.idx_b : {3'b0, ifa.idx_b};
  assign o_tw    = sel ? {1'b0, ifb.tw_idx} : {4'b0, ifa.tw_idx};
  assign o_st    = sel ? ifb.stage : {1'b0, ifa.stage};
  assign o_valid = sel ? ifb.bf_valid : ifa.bf_valid;
  assign o_load  = sel ? lb : la;
  assign o_busy  = sel ? bb : ba;
  assign o_done  = sel ? db : da;
`ifdef FFT_SEQ_STALL_CNT_EN
  assign o_stall = sel ? sb : sa;
`endif

  typedef struct { int a; int b; int tw; int s; } bf_t;
  bf_t q[$];
  int last_a, last_b, last_tw, last_s;

  task automatic use_dut(input bit s);
    sel = s;
    N = s ? 64 : 8;
    L = s ? 6 : 3;
    P = s ? 0 : 2;
  endtask

  task automatic build_model();
    bf_t e;
    int span, pos, grp;
    q.delete();
    for (int s = 0; s < L; s++) begin
      for (int k = 0; k < N / 2; k++) begin
        span = 1 << s;
        pos  = k % span;
        grp  = k / span;
        e.a  = grp * 2 * span + pos;
        e.b  = e.a + span;
        e.tw = pos * (1 << (L - 1 - s));
        e.s  = s;
        q.push_back(e);
      end
    end
  endtask

  task automatic settle();
    abort = 1'b1;
    start = 1'b0;
    rdy   = 1'b0;
    @(posedge clk);
    abort = 1'b0;
    @(posedge clk);
  endtask

  // mode 0: ready high, 1: random ready + stray start, 2: 3-cycle stall
  task automatic run_seq(input int mode, input bit hold);
    int c, stalls, pops, stall_left, budget, exp_c, blk;
    bit nr, exp_v;
    bf_t h;
    build_model();
    stalls = 0; pops = 0; stall_left = 3; budget = 0;
    rdy = (mode != 1);
    start = 1'b1;
    do begin
      @(posedge clk);
      budget++;
    end while (!o_load && budget < 5);
    total++;
    if (o_load !== 1'b1) begin
      $display("FAIL load_start got=%0b want=1", o_load);
      bad++;
      return;
    end
    if (!hold) start = 1'b0;
    c = 0;
    blk = N / 2 + P;
    while (c < 3000) begin
      total++;
      if (o_busy !== 1'b1) begin
        $display("FAIL busy_run c=%0d got=%0b want=1", c, o_busy);
        bad++;
      end
      if (mode == 0) begin
        exp_v = (c >= 1) && ((c - 1) / blk < L) && ((c - 1) % blk < N / 2);
        total++;
        if (o_valid !== exp_v) begin
          $display("FAIL valid_timing c=%0d got=%0b want=%0b", c, o_valid, exp_v);
          bad++;
        end
      end
      if (o_done === 1'b1) break;
      nr = (mode != 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (o_valid === 1'b1) begin
        total++;
        if (q.size() == 0) begin
          $display("FAIL extra_bf c=%0d got=a%0d want=none", c, o_a);
          bad++;
        end else begin
          h = q[0];
          if (o_a !== 6'(h.a) || o_b !== 6'(h.b) || o_tw !== 6'(h.tw) || o_st !== 3'(h.s)) begin
            $display("FAIL bf_idx c=%0d got=(%0d,%0d,%0d,s%0d) want=(%0d,%0d,%0d,s%0d)",
                     c, o_a, o_b, o_tw, o_st, h.a, h.b, h.tw, h.s);
            bad++;
          end
          last_a = o_a; last_b = o_b; last_tw = o_tw; last_s = o_st;
        end
        if (mode == 2 && pops == N / 2 + 2 && stall_left > 0) begin
          nr = 1'b0;
          stall_left--;
        end
        if (nr) begin
          if (q.size() > 0) void'(q.pop_front());
          pops++;
        end else begin
          stalls++;
        end
      end
      if (!hold) start = (mode == 1 && c == 5);
      rdy = nr;
      @(posedge clk);
      c++;
    end
    total++;
    if (o_done !== 1'b1) begin
      $display("FAIL done_timeout got=%0b want=1", o_done);
      bad++;
      return;
    end
    exp_c = 1 + L * blk + stalls;
    total++;
    if (c != exp_c) begin
      $display("FAIL done_cycle got=%0d want=%0d", c, exp_c);
      bad++;
    end
    total++;
    if (q.size() != 0) begin
      $display("FAIL bf_count got=%0d want=0 left", q.size());
      bad++;
    end
`ifdef FFT_SEQ_STALL_CNT_EN
    total++;
    if (o_stall !== 16'(stalls)) begin
      $display("FAIL stall_cnt got=%0d want=%0d", o_stall, stalls);
      bad++;
    end
`endif
    rdy = 1'b0;
    @(posedge clk);
    total++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_load !== 1'b0) begin
      $display("FAIL after_done got=d%0b b%0b l%0b want=0,0,0", o_done, o_busy, o_load);
      bad++;
    end
    if (!hold) begin
      @(posedge clk);
      total++;
      if (o_load !== 1'b0) begin
        $display("FAIL no_queue got=%0b want=0", o_load);
        bad++;
      end
    end
  endtask

  task automatic test_reset();
    use_dut(0);
    repeat (2) @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      use_dut(d[0]);
      #1;
      total++;
      if ({o_valid, o_load, o_busy, o_done, o_a, o_b, o_tw, o_st} !== '0) begin
        $display("FAIL reset_state dut=%0d got=%0b want=0", d,
                 {o_valid, o_load, o_busy, o_done, o_a, o_b, o_tw, o_st});
        bad++;
      end
    end
    @(posedge clk);
    rst = 1'b1;
    use_dut(0);
    @(posedge clk);
  endtask

  task automatic test_full_seq();
    use_dut(0);
    settle();
    run_seq(0, 1'b0);
  endtask

  task automatic test_stall();
    use_dut(0);
    settle();
    run_seq(2, 1'b0);
  endtask

  task automatic test_abort();
    int dones;
    use_dut(0);
    settle();
    rdy = 1'b1;
    start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    repeat (11) @(posedge clk);
    total++;
    if (o_valid !== 1'b0 || o_st !== 3'd1 || o_busy !== 1'b1) begin
      $display("FAIL abort_pre got=v%0b s%0d want=v0 s1", o_valid, o_st);
      bad++;
    end
    abort = 1'b1;
    @(posedge clk);
    abort = 1'b0;
    total++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_st !== 3'd0) begin
      $display("FAIL abort_idle got=b%0b d%0b s%0d want=0,0,0", o_busy, o_done, o_st);
      bad++;
    end
    dones = 0;
    repeat (25) begin
      @(posedge clk);
      if (o_done === 1'b1) dones++;
    end
    total++;
    if (dones != 0) begin
      $display("FAIL abort_no_done got=%0d want=0", dones);
      bad++;
    end
    run_seq(0, 1'b0);
  endtask

  task automatic test_async_reset();
    use_dut(0);
    settle();
    rdy = 1'b1;
    start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if ({o_valid, o_load, o_busy, o_done, o_a, o_b, o_tw, o_st} !== '0) begin
      $display("FAIL async_reset got=%0b want=0",
               {o_valid, o_load, o_busy, o_done, o_a, o_b, o_tw, o_st});
      bad++;
    end
    @(posedge clk);
    rst = 1'b1;
    rdy = 1'b0;
    @(posedge clk);
    run_seq(0, 1'b0);
  endtask

  task automatic test_start_held();
    use_dut(0);
    settle();
    run_seq(0, 1'b1);
    @(posedge clk);
    total++;
    if (o_load !== 1'b1) begin
      $display("FAIL reload got=%0b want=1", o_load);
      bad++;
    end
    settle();
  endtask

  task automatic test_random();
    for (int d = 0; d < 2; d++) begin
      use_dut(d[0]);
      settle();
      run_seq(1, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    use_dut(1);
    settle();
    run_seq(0, 1'b0);
    total++;
    if (last_a != 31 || last_b != 63 || last_tw != 31 || last_s != 5) begin
      $display("FAIL last_bf got=(%0d,%0d,%0d,s%0d) want=(31,63,31,s5)",
               last_a, last_b, last_tw, last_s);
      bad++;
    end
    use_dut(0);
    run_seq(0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_full_seq();
    test_stall();
    test_abort();
    test_async_reset();
    test_start_held();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
Control block for the in-place radix-2 DIT butterfly datapath. On a start request it performs one load of the sample registers, then issues every butterfly of every stage. For each butterfly it supplies the register pair indices, the twiddle index and a valid/ready handshake. Between stages it drains the datapath pipeline, then signals completion. It replaces the free-running count/stage chain with one explicit FSM clocked on the same edge as the sample registers.

Parameters:
N_POINTS, 64, FFT size; power of two, >= 4
LOG2_N, 6, log2(N_POINTS); sets the stage count and the index widths
PIPE_DEPTH, 2, cycles the datapath needs after its last accepted butterfly before those results are readable; range 0..7

Ports:
clk  in  1  clock; all state updates on the falling edge
rst  in  1  reset, asynchronous, active-low
start  in  1  request a transform; sampled only in IDLE
abort  in  1  synchronous abort; returns to IDLE from any state
bf_ready  in  1  datapath accepts the current butterfly
load_en  out  1  one-cycle strobe: sample registers capture the input vector
bf_valid  out  1  a butterfly is presented on idx_a, idx_b and tw_idx
idx_a  out  LOG2_N  upper-leg register index
idx_b  out  LOG2_N  lower-leg register index (idx_a + span)
tw_idx  out  LOG2_N-1  twiddle ROM index
stage  out  $clog2(LOG2_N)  current stage number, 0-based
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE and all counters clear. Every output is 0.
- States and transitions:
  - IDLE: start=1 -> LOAD.
  - LOAD: load_en=1 for exactly one cycle, then -> RUN with stage=0, k=0.
  - RUN: bf_valid=1. A butterfly is accepted when bf_valid and bf_ready are both high.
    - Accepted with k < N/2-1: k increments.
    - Accepted with k = N/2-1: -> FLUSH, or directly to the next stage if PIPE_DEPTH=0.
  - FLUSH: bf_valid=0 for PIPE_DEPTH cycles. Then:
    - if stage < LOG2_N-1: stage increments, k=0, -> RUN.
    - otherwise -> DONE.
  - DONE: done=1 for one cycle, then -> IDLE.
- Index arithmetic, with s = stage and span = 2^s:
  - pos = k mod span; grp = k >> s
  - idx_a = grp*2*span + pos; idx_b = idx_a + span
  - tw_idx = pos << (LOG2_N-1-s)
  - All results are exact; no wrap-around is possible within range.
- Handshake rules:
  - Outputs are registered.
  - While bf_valid=1 and bf_ready=0, idx_a, idx_b, tw_idx and stage hold stable. bf_valid never drops before acceptance.
  - bf_valid=0 in all states other than RUN. In those states idx_a, idx_b and tw_idx hold their last values.
- Boundary and simultaneous events:
  - start outside IDLE is ignored; no queuing.
  - abort has priority over every transition, including start in IDLE and the DONE pulse.
    - The next state is IDLE with counters cleared.
    - done is not pulsed, and a pending butterfly is dropped.
  - Reset mid-operation behaves like abort, but asynchronously.
  - bf_ready=1 outside RUN has no effect.
- Throughput with bf_ready held high: 1 + LOG2_N*(N/2 + PIPE_DEPTH) cycles from LOAD to the cycle before DONE.

Optional Feature:
FFT_SEQ_STALL_CNT_EN
- Defined:
  - Adds output stall_cnt [15:0], which counts cycles where bf_valid=1 and bf_ready=0.
  - Saturates at 16'hFFFF.
  - Clears on reset and when the FSM enters LOAD.
  - Holds its value after DONE until the next LOAD.
- Undefined: the port and the counter are absent, and the rest of the behaviour is identical.

Test Plan:
1. N_POINTS=8, LOG2_N=3, PIPE_DEPTH=2, bf_ready=1, start pulse. Expected response:
   - LOAD in cycle 0.
   - Stage 0 (cycles 1-4): pairs (0,1)(2,3)(4,5)(6,7), all tw 0.
   - Flush in cycles 5-6.
   - Stage 1 (cycles 7-10): pairs (0,2)(1,3)(4,6)(5,7), tw 0,2,0,2.
   - Flush in cycles 11-12.
   - Stage 2 (cycles 13-16): pairs (0,4)(1,5)(2,6)(3,7), tw 0,1,2,3.
   - Flush in cycles 17-18.
   - done=1 in cycle 19, then busy=0.
2. Same configuration with bf_ready low for 3 cycles at stage 1, k=2 -> idx_a=4, idx_b=6, tw_idx=0 held for 4 cycles; the whole sequence shifts by 3 cycles; with FFT_SEQ_STALL_CNT_EN, stall_cnt=3.
3. abort asserted in stage 1 FLUSH -> IDLE on the next edge, busy=0, no done. A new start then gives LOAD and stage 0 from k=0.
4. rst driven low mid-RUN, between clock edges -> all outputs 0 immediately; after release, start gives the full sequence of scenario 1.
5. start held high through the entire transform -> exactly one done, then a second LOAD on the cycle after IDLE is re-entered. start pulsed during RUN -> ignored.
6. N_POINTS=64, LOG2_N=6, PIPE_DEPTH=0, bf_ready=1 -> 192 butterflies back to back, done 193 cycles after LOAD. Last butterfly is idx_a=31, idx_b=63, tw_idx=31, stage=5.
